// File: rtl/axi_rd_port_arbiter_if.sv
// Read-side AXI bundle for the port arbiter: per-requester AR/R lanes plus the shared
// downstream AR/R master channel. "master" is the arbiter's view, "slave" the surroundings'.
interface axi_rd_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 256
);
    logic [NUM_REQ-1:0]        req_arvalid;
    logic [NUM_REQ-1:0]        req_arready;
    logic [NUM_REQ*ADDR_W-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]      req_arlen;
    logic [NUM_REQ*3-1:0]      req_arsize;
    logic [NUM_REQ-1:0]        req_rvalid;
    logic [NUM_REQ-1:0]        req_rready;
    logic [DATA_W-1:0]         req_rdata;
    logic                      req_rlast;

    logic                      m_axi_arvalid;
    logic                      m_axi_arready;
    logic [ADDR_W-1:0]         m_axi_araddr;
    logic [7:0]                m_axi_arlen;
    logic [2:0]                m_axi_arsize;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;
    logic [DATA_W-1:0]         m_axi_rdata;
    logic                      m_axi_rlast;

    modport master (
        input  req_arvalid, req_araddr, req_arlen, req_arsize, req_rready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        output req_arready, req_rvalid, req_rdata, req_rlast,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_rready
    );

    modport slave (
        output req_arvalid, req_araddr, req_arlen, req_arsize, req_rready,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        input  req_arready, req_rvalid, req_rdata, req_rlast,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_rready
    );
endinterface

// File: rtl/axi_rd_port_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master among NUM_REQ requesters.
// One burst in flight; the grant is held from the AR handshake through the rlast beat.
module axi_rd_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 256,
    parameter int ID_W    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_rd_port_arbiter_if.master  bus,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                          state;
    logic [ID_W-1:0]                 rr_ptr;
    logic [ID_W-1:0]                 nxt_g;
    logic [NUM_REQ-1:0]              sel;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_v;
    logic [NUM_REQ-1:0][7:0]         len_v;
    logic [NUM_REQ-1:0][2:0]         size_v;

    assign addr_v = bus.req_araddr;
    assign len_v  = bus.req_arlen;
    assign size_v = bus.req_arsize;

    // Winner is the requesting index with the smallest rotational distance from rr_ptr.
    always_comb begin
        int best;
        int off;
        best  = NUM_REQ;
        off   = 0;
        nxt_g = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            off = (i - int'(rr_ptr) + NUM_REQ) % NUM_REQ;
            if (bus.req_arvalid[i] && off < best) begin
                best  = off;
                nxt_g = ID_W'(i);
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign sel[i]             = (grant_id == ID_W'(i));
        assign bus.req_arready[i] = (state == ADDR) && sel[i] && bus.m_axi_arready;
        assign bus.req_rvalid[i]  = (state == DATA) && sel[i] && bus.m_axi_rvalid;
    end

    assign bus.req_rdata = bus.m_axi_rdata;
    assign bus.req_rlast = bus.m_axi_rlast;

    always_comb begin
        bus.m_axi_arvalid = 1'b0;
        bus.m_axi_araddr  = '0;
        bus.m_axi_arlen   = '0;
        bus.m_axi_arsize  = '0;
        bus.m_axi_rready  = 1'b0;
        if (state == ADDR) begin
            bus.m_axi_arvalid = bus.req_arvalid[grant_id];
            bus.m_axi_araddr  = addr_v[grant_id];
            bus.m_axi_arlen   = len_v[grant_id];
            bus.m_axi_arsize  = size_v[grant_id];
        end
        if (state == DATA)
            bus.m_axi_rready = bus.req_rready[grant_id];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.req_arvalid) begin
                    grant_id <= nxt_g;
                    state    <= ADDR;
                    busy     <= 1'b1;
                end
                ADDR: begin
                    // Upstream withdrew its request: drop back without advancing rr_ptr.
                    if (!bus.req_arvalid[grant_id]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bus.m_axi_arready) begin
                        state <= DATA;
                    end
                end
                DATA: if (bus.m_axi_rvalid && bus.req_rready[grant_id] && bus.m_axi_rlast) begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
